// File: rtl/wb_pkg.sv
// Shared sizing constants for the register-file writeback slice.
package wb_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = 3;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/pending_scoreboard.sv
// Per-register pending-write counters. Each counter tracks how many issued
// writes to that register have not yet committed or been flushed.
module pending_scoreboard #(
  parameter int ADDR_W   = wb_pkg::ADDR_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS,
  parameter int CNT_W    = wb_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_en,
  input  logic [ADDR_W-1:0]   inc_addr,
  input  logic                commit_en,
  input  logic [ADDR_W-1:0]   commit_addr,
  input  logic                rel_en,
  input  logic [ADDR_W-1:0]   rel_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] full,
  output logic                error
);
  import wb_pkg::*;

  // Two extra bits hold the signed range cnt+1 .. cnt-2 without wrapping.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0]        cnt     [NUM_REGS];
  logic [CNT_W-1:0]        cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]     under;
  logic signed [SUM_W-1:0] sum;

  function automatic logic signed [SUM_W-1:0] net_count(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             com,
    input logic             rel
  );
    net_count = $signed(SUM_W'(c)) + $signed(SUM_W'(inc))
              - $signed(SUM_W'(com)) - $signed(SUM_W'(rel));
  endfunction

  // Negative results clamp to zero; the caller flags that case separately.
  function automatic logic [CNT_W-1:0] clamp_count(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])
      clamp_count = '0;
    else if (s > $signed(SUM_W'(FULL_LVL)))
      clamp_count = FULL_LVL;
    else
      clamp_count = s[CNT_W-1:0];
  endfunction

  // Next counter values; register 0 never holds a reservation.
  always_comb begin
    under = '0;
    sum   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r != ZERO_REG) begin
        sum = net_count(cnt[r],
                        inc_en    & (inc_addr    == ADDR_W'(r)),
                        commit_en & (commit_addr == ADDR_W'(r)),
                        rel_en    & (rel_addr    == ADDR_W'(r)));
        cnt_nxt[r] = clamp_count(sum);
        under[r]   = sum[SUM_W-1];
      end
    end
  end

  // Counter array update; reset drops every outstanding reservation.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst)
        cnt[r] <= '0;
      else
        cnt[r] <= cnt_nxt[r];
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      error <= 1'b0;
    else if (|under)
      error <= 1'b1;
  end

  // Per-register status seen by the hazard and issue logic.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt[r] != '0);
      full[r] = (cnt[r] == FULL_LVL);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB pipeline register, result select, register-file
// write port, retire counter and RAW-hazard / issue-ready generation.
module writeback_unit #(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int ADDR_W   = wb_pkg::ADDR_W,
  parameter int NUM_REGS = wb_pkg::NUM_REGS,
  parameter int CNT_W    = wb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              wb_flush,
  input  logic              issue_valid,
  input  logic              issue_reg_write,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              hazard_stall,
  output logic              regWrite,
  output logic [ADDR_W-1:0] write_reg_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       retired_count,
  output logic              sb_error
);
  import wb_pkg::*;

  localparam logic [ADDR_W-1:0] REG0 = ADDR_W'(ZERO_REG);

  logic                vld_p0;
  logic                wr_p0;
  logic [DATA_W-1:0]   data_p0;
  logic                vld_p1;
  logic                wr_p1;
  logic                inc_en;
  logic                rel_en;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] full;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] load_data,
    input logic [DATA_W-1:0] alu_result
  );
    wb_select = mem_to_reg ? load_data : alu_result;
  endfunction

  // ---- p0: MEM-stage inputs, qualified by flush and register 0 ----
  assign vld_p0  = mem_valid & ~wb_flush;
  assign wr_p0   = vld_p0 & mem_reg_write & (mem_dest != REG0);
  assign data_p0 = wb_select(mem_mem_to_reg, mem_load_data, mem_alu_result);

  // MEM/WB register: one entry per edge, no hold, reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      wr_p1          <= 1'b0;
      write_reg_addr <= '0;
      write_data     <= '0;
    end else begin
      vld_p1         <= vld_p0;
      wr_p1          <= wr_p0;
      write_reg_addr <= mem_dest;
      write_data     <= data_p0;
    end
  end

  // ---- p1: write port toward the register file ----
  // Masking with rst keeps an in-flight entry from committing at a reset edge.
  assign regWrite = wr_p1 & ~rst;

  // Retire count advances for every valid entry, writing or not.
  always_ff @(posedge clk) begin
    if (rst)
      retired_count <= '0;
    else if (vld_p1)
      retired_count <= retired_count + 16'd1;
  end

  // Scoreboard events: accepted issue reserves, commit and flush release.
  assign inc_en = issue_valid & issue_ready & issue_reg_write;
  assign rel_en = mem_valid & wb_flush & mem_reg_write;

  pending_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .inc_en      (inc_en),
    .inc_addr    (issue_dest),
    .commit_en   (regWrite),
    .commit_addr (write_reg_addr),
    .rel_en      (rel_en),
    .rel_addr    (mem_dest),
    .busy        (busy),
    .full        (full),
    .error       (sb_error)
  );

  // A saturated counter cannot take another reservation.
  assign issue_ready  = ~rst & ~(issue_reg_write & full[issue_dest]);

  // Any source with an outstanding write must wait; register 0 never stalls.
  assign hazard_stall = ((id_rs != REG0) & busy[id_rs]) |
                        ((id_rt != REG0) & busy[id_rt]);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a behavioural pending-write model.
module tb_writeback_unit;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_valid = 1'b0;
  logic          mem_reg_write = 1'b0;
  logic          mem_mem_to_reg = 1'b0;
  logic [AW-1:0] mem_dest = '0;
  logic [DW-1:0] mem_alu_result = '0;
  logic [DW-1:0] mem_load_data = '0;
  logic          wb_flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_reg_write = 1'b0;
  logic [AW-1:0] issue_dest = '0;
  logic          issue_ready;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic          hazard_stall;
  logic          regWrite;
  logic [AW-1:0] write_reg_addr;
  logic [DW-1:0] write_data;
  logic [15:0]   retired_count;
  logic          sb_error;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_dest(mem_dest),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .wb_flush(wb_flush),
    .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
    .issue_dest(issue_dest), .issue_ready(issue_ready),
    .id_rs(id_rs), .id_rt(id_rt), .hazard_stall(hazard_stall),
    .regWrite(regWrite), .write_reg_addr(write_reg_addr),
    .write_data(write_data), .retired_count(retired_count),
    .sb_error(sb_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending counts per register plus the one-deep WB entry.
  int m_cnt [NR];
  bit m_vld, m_wr, m_err, armed;
  int m_addr, m_data, m_ret;

  always @(posedge clk) begin : model
    int delta [NR];
    int v;
    bit rdy;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      m_vld = 0; m_wr = 0; m_addr = 0; m_data = 0; m_ret = 0; m_err = 0;
      armed = 1;
    end else begin
      for (int r = 0; r < NR; r++) delta[r] = 0;
      rdy = !(issue_reg_write && m_cnt[issue_dest] == 3);
      if (issue_valid && rdy && issue_reg_write && issue_dest != 0) delta[issue_dest]++;
      if (m_wr) delta[m_addr]--;
      if (mem_valid && wb_flush && mem_reg_write && mem_dest != 0) delta[mem_dest]--;
      for (int r = 0; r < NR; r++) begin
        v = m_cnt[r] + delta[r];
        if (v < 0) begin v = 0; m_err = 1; end
        m_cnt[r] = v;
      end
      if (m_vld) m_ret = (m_ret + 1) % 65536;
      m_vld  = mem_valid && !wb_flush;
      m_wr   = m_vld && mem_reg_write && mem_dest != 0;
      m_addr = mem_dest;
      m_data = mem_mem_to_reg ? mem_load_data : mem_alu_result;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit e_rdy, e_haz;
    if (armed) begin
      e_rdy = !rst && !(issue_reg_write && m_cnt[issue_dest] == 3);
      e_haz = (id_rs != 0 && m_cnt[id_rs] != 0) || (id_rt != 0 && m_cnt[id_rt] != 0);
      chk("m_regWrite", regWrite, m_wr && !rst);
      chk("m_addr", write_reg_addr, m_addr);
      chk("m_data", write_data, m_data);
      chk("m_retired", retired_count, m_ret);
      chk("m_sb_error", sb_error, m_err);
      chk("m_issue_ready", issue_ready, e_rdy);
      chk("m_hazard", hazard_stall, e_haz);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_reg_write = 0; mem_mem_to_reg = 0; mem_dest = '0;
    mem_alu_result = '0; mem_load_data = '0; wb_flush = 0;
    issue_valid = 0; issue_reg_write = 0; issue_dest = '0;
    id_rs = '0; id_rt = '0;
  endtask

  task automatic rnd();
    mem_valid = 1'($urandom); mem_reg_write = 1'($urandom);
    mem_mem_to_reg = 1'($urandom); mem_dest = AW'($urandom);
    mem_alu_result = DW'($urandom); mem_load_data = DW'($urandom);
    wb_flush = 1'($urandom); issue_valid = 1'($urandom);
    issue_reg_write = 1'($urandom); issue_dest = AW'($urandom);
    id_rs = AW'($urandom); id_rt = AW'($urandom);
  endtask

  initial begin
    // Reset with random inputs.
    idle(); rst = 1; rnd();
    cyc(); rnd();
    @(negedge clk);
    chk("rst_regWrite", regWrite, 0);
    chk("rst_ready", issue_ready, 0);
    chk("rst_addr", write_reg_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_sb_error", sb_error, 0);
    chk("rst_hazard", hazard_stall, 0);
    cyc();
    rst = 0; idle();
    issue_reg_write = 1; issue_dest = 5; id_rs = 5;
    @(negedge clk);
    chk("post_rst_ready", issue_ready, 1);
    chk("post_rst_hazard", hazard_stall, 0);

    // Basic write to r5.
    issue_valid = 1;
    cyc(); idle(); id_rs = 5;
    @(negedge clk);
    chk("r5_pending", hazard_stall, 1);
    mem_valid = 1; mem_reg_write = 1; mem_dest = 5;
    mem_alu_result = 8'h2A; mem_load_data = 8'h99; mem_mem_to_reg = 0;
    cyc(); idle(); id_rs = 5;
    @(negedge clk);
    chk("r5_we", regWrite, 1);
    chk("r5_addr", write_reg_addr, 5);
    chk("r5_data", write_data, 8'h2A);
    chk("r5_still_pending", hazard_stall, 1);
    cyc();
    @(negedge clk);
    chk("r5_bubble", regWrite, 0);
    chk("r5_released", hazard_stall, 0);
    chk("r5_retired", retired_count, 1);

    // Load into r3, then same load to r0.
    issue_valid = 1; issue_reg_write = 1; issue_dest = 3;
    cyc(); idle();
    mem_valid = 1; mem_reg_write = 1; mem_mem_to_reg = 1;
    mem_load_data = 8'h7F; mem_alu_result = 8'h11; mem_dest = 3;
    cyc(); idle();
    @(negedge clk);
    chk("ld_we", regWrite, 1);
    chk("ld_addr", write_reg_addr, 3);
    chk("ld_data", write_data, 8'h7F);
    cyc();
    mem_valid = 1; mem_reg_write = 1; mem_mem_to_reg = 1;
    mem_load_data = 8'h7F; mem_dest = 0;
    cyc(); idle();
    @(negedge clk);
    chk("r0_no_write", regWrite, 0);
    chk("r0_retired_before", retired_count, 2);
    cyc();
    @(negedge clk);
    chk("r0_retired_after", retired_count, 3);

    // Saturate r7.
    issue_valid = 1; issue_reg_write = 1; issue_dest = 7;
    repeat (3) cyc();
    @(negedge clk);
    chk("sat_not_ready", issue_ready, 0);
    cyc(); idle();
    issue_reg_write = 1; issue_dest = 7;
    mem_valid = 1; mem_reg_write = 1; mem_dest = 7; mem_alu_result = 8'h01;
    cyc(); mem_valid = 0;
    @(negedge clk);
    chk("sat_commit_we", regWrite, 1);
    chk("sat_still_full", issue_ready, 0);
    cyc();
    @(negedge clk);
    chk("sat_ready_again", issue_ready, 1);
    idle(); mem_valid = 1; mem_reg_write = 1; mem_dest = 7; mem_alu_result = 8'h02;
    cyc(); mem_alu_result = 8'h03;
    cyc(); idle();
    cyc(); id_rs = 7;
    @(negedge clk);
    chk("sat_drained", hazard_stall, 0);

    // Flush returns a reservation; flush without one underflows.
    idle(); issue_valid = 1; issue_reg_write = 1; issue_dest = 9;
    cyc(); idle();
    mem_valid = 1; mem_reg_write = 1; mem_dest = 9; wb_flush = 1; id_rs = 9;
    @(negedge clk);
    chk("fl_pending", hazard_stall, 1);
    cyc(); idle(); id_rs = 9;
    @(negedge clk);
    chk("fl_no_write", regWrite, 0);
    chk("fl_cleared", hazard_stall, 0);
    chk("fl_no_err", sb_error, 0);
    mem_valid = 1; mem_reg_write = 1; mem_dest = 10; wb_flush = 1;
    cyc(); idle();
    @(negedge clk);
    chk("fl_underflow", sb_error, 1);
    chk("fl_retired", retired_count, 6);

    // Issue, commit and release on r4 in one edge with cnt=2.
    issue_valid = 1; issue_reg_write = 1; issue_dest = 4;
    cyc();
    mem_valid = 1; mem_reg_write = 1; mem_dest = 4; mem_alu_result = 8'h44;
    cyc();
    wb_flush = 1;
    cyc(); idle(); id_rs = 4;
    @(negedge clk);
    chk("sim_cnt1_busy", hazard_stall, 1);
    mem_valid = 1; mem_reg_write = 1; mem_dest = 4; mem_alu_result = 8'h45;
    cyc(); idle(); id_rs = 4;
    cyc();
    @(negedge clk);
    chk("sim_cnt1_done", hazard_stall, 0);
    chk("sim_err_sticky", sb_error, 1);

    // Back-to-back writes.
    idle(); issue_valid = 1; issue_reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      issue_dest = AW'(11 + i);
      cyc();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_reg_write = 1; mem_dest = AW'(11 + i);
      mem_alu_result = DW'(8'h50 + i);
      cyc();
      @(negedge clk);
      chk("b2b_we", regWrite, 1);
      chk("b2b_addr", write_reg_addr, 11 + i);
      chk("b2b_data", write_data, 8'h50 + i);
    end
    idle();
    cyc(); cyc();

    // Reset while a write is in flight.
    issue_valid = 1; issue_reg_write = 1; issue_dest = 6;
    cyc(); idle();
    mem_valid = 1; mem_reg_write = 1; mem_dest = 6; mem_alu_result = 8'h66;
    cyc(); idle(); rst = 1;
    @(negedge clk);
    chk("mid_rst_no_write", regWrite, 0);
    cyc();
    rst = 0; id_rs = 6; issue_reg_write = 1; issue_dest = 6;
    @(negedge clk);
    chk("mid_rst_after_we", regWrite, 0);
    chk("mid_rst_retired", retired_count, 0);
    chk("mid_rst_err", sb_error, 0);
    chk("mid_rst_hazard", hazard_stall, 0);
    chk("mid_rst_ready", issue_ready, 1);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
